calc_controller: RTL and testbench

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_calc_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// calc_controller: keypad-driven integer calculator controller.
//
// Two operands (0..255) are typed in as decimal digits, combined with one
// operator (add, sub, mul) and evaluated on equals. Add/sub finish in one
// cycle; mul uses an 8-step shift-add, one multiplier bit per cycle, LSB first.
// Results above RESULT_MAX, or a subtraction that would go negative, drop the
// controller into an error state that only clear (or reset) leaves.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_valid   one-cycle pulse qualifying key_code
//   key_code    0-9 digit, 10 add, 11 sub, 12 mul, 13 equals, 14 clear, 15 reserved
//   num_input   operand currently being entered
//   op_display  0 none, 1 add, 2 sub, 3 mul
//   result      last computed result
//   busy        high while a computation is in progress
//   err         high in the error state
//   state_dbg   current FSM state (S_A=0, S_B=1, S_CALC=2, S_DONE=3, S_ERR=4)
//
// Key handshake: a key is consumed on the rising edge where key_valid is high;
// there is no backpressure, so keys that are not legal in the current state
// (or any key but clear while busy) are silently dropped.
module calc_controller #(
  parameter int RESULT_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [7:0]  num_input,
  output logic [1:0]  op_display,
  output logic [15:0] result,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] RMAX = 32'(RESULT_MAX);

  state_t      state, state_n;
  logic [7:0]  num_n;
  logic [1:0]  op_n;
  logic [15:0] result_n;
  logic        busy_n, err_n;
  logic [7:0]  opa, opa_n, opb, opb_n;
  logic [15:0] acc, acc_n, mcand, mcand_n;
  logic [7:0]  mplier, mplier_n;
  logic [2:0]  step, step_n;

  // Key decode
  logic        is_digit, is_op, is_eq, is_clr;
  logic [3:0]  op_tmp;
  logic [1:0]  key_op;
  logic [11:0] digit_acc;
  logic        digit_ok;

  always_comb begin
    is_digit  = key_valid && (key_code <= 4'd9);
    is_op     = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    is_eq     = key_valid && (key_code == 4'd13);
    is_clr    = key_valid && (key_code == 4'd14);
    op_tmp    = key_code - 4'd9;
    key_op    = op_tmp[1:0];
    digit_acc = {4'b0, num_input} * 12'd10 + {8'b0, key_code};
    // A digit that would push the operand past 8 bits is dropped.
    digit_ok  = (digit_acc <= 12'd255);
  end

  // Datapath for the S_CALC cycle
  logic [15:0] mul_step;
  logic [15:0] calc_value;
  logic        calc_done, calc_bad;

  always_comb begin
    mul_step   = acc + (mplier[0] ? mcand : 16'd0);
    calc_value = 16'd0;
    calc_done  = 1'b1;
    case (op_display)
      2'd1: calc_value = {8'b0, opa} + {8'b0, opb};
      2'd2: calc_value = {8'b0, opa - opb};
      2'd3: begin
        calc_value = mul_step;
        calc_done  = (step == 3'd7);
      end
      default: calc_value = 16'd0;
    endcase
    calc_bad = ((op_display == 2'd2) && (opa < opb)) ||
               ({16'b0, calc_value} > RMAX);
  end

  // Next-state / next-output logic
  always_comb begin
    state_n  = state;
    num_n    = num_input;
    op_n     = op_display;
    result_n = result;
    busy_n   = busy;
    err_n    = err;
    opa_n    = opa;
    opb_n    = opb;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    step_n   = step;

    if (is_clr) begin
      state_n  = S_A;
      num_n    = 8'd0;
      op_n     = 2'd0;
      result_n = 16'd0;
      busy_n   = 1'b0;
      err_n    = 1'b0;
      opa_n    = 8'd0;
      opb_n    = 8'd0;
      acc_n    = 16'd0;
      mcand_n  = 16'd0;
      mplier_n = 8'd0;
      step_n   = 3'd0;
    end else begin
      case (state)
        S_A: begin
          if (is_digit && digit_ok) begin
            num_n = digit_acc[7:0];
          end else if (is_op) begin
            opa_n   = num_input;
            op_n    = key_op;
            num_n   = 8'd0;
            state_n = S_B;
          end
        end
        S_B: begin
          if (is_digit && digit_ok) begin
            num_n = digit_acc[7:0];
          end else if (is_op) begin
            op_n = key_op;
          end else if (is_eq) begin
            opb_n    = num_input;
            acc_n    = 16'd0;
            mcand_n  = {8'b0, opa};
            mplier_n = num_input;
            step_n   = 3'd0;
            busy_n   = 1'b1;
            state_n  = S_CALC;
          end
        end
        S_CALC: begin
          // Multiplier registers advance every cycle; they are only
          // consumed when op_display selects mul.
          acc_n    = mul_step;
          mcand_n  = {mcand[14:0], 1'b0};
          mplier_n = {1'b0, mplier[7:1]};
          step_n   = step + 3'd1;
          if (calc_done) begin
            busy_n = 1'b0;
            if (calc_bad) begin
              result_n = 16'd0;
              err_n    = 1'b1;
              state_n  = S_ERR;
            end else begin
              result_n = calc_value;
              state_n  = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (is_digit) begin
            num_n   = {4'b0, key_code};
            op_n    = 2'd0;
            state_n = S_A;
          end else if (is_op && (result <= 16'd255)) begin
            opa_n   = result[7:0];
            op_n    = key_op;
            num_n   = 8'd0;
            state_n = S_B;
          end
        end
        S_ERR: begin
          // Only clear leaves the error state.
        end
        default: state_n = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_A;
      num_input  <= 8'd0;
      op_display <= 2'd0;
      result     <= 16'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
      opa        <= 8'd0;
      opb        <= 8'd0;
      acc        <= 16'd0;
      mcand      <= 16'd0;
      mplier     <= 8'd0;
      step       <= 3'd0;
    end else begin
      state      <= state_n;
      num_input  <= num_n;
      op_display <= op_n;
      result     <= result_n;
      busy       <= busy_n;
      err        <= err_n;
      opa        <= opa_n;
      opb        <= opb_n;
      acc        <= acc_n;
      mcand      <= mcand_n;
      mplier     <= mplier_n;
      step       <= step_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_calc_controller.sv
// Directed testbench for calc_controller. Inputs change on the falling edge,
// outputs are checked on the falling edge, half a period after the rising
// edge that consumed the key.
module tb_calc_controller;

  localparam logic [2:0] ST_A    = 3'd0;
  localparam logic [2:0] ST_B    = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_EQ  = 4'd13;
  localparam logic [3:0] K_CLR = 4'd14;
  localparam logic [3:0] K_RSV = 4'd15;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [7:0]  num_input;
  logic [1:0]  op_display;
  logic [15:0] result;
  logic        busy, err;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int n;

  calc_controller #(.RESULT_MAX(9999)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .num_input(num_input), .op_display(op_display), .result(result),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // Driver: called at a falling edge, key is consumed by the next rising edge,
  // returns at the following falling edge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count falling edges with busy high, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_A));
    chk({tag, "_num"}, 32'(num_input), 32'd0);
    chk({tag, "_op"}, 32'(op_display), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 12 + 34 = 46
    press(4'd1); chk("a_d1", 32'(num_input), 32'd1);
    press(4'd2); chk("a_d12", 32'(num_input), 32'd12);
    press(K_ADD);
    chk("add_op", 32'(op_display), 32'd1);
    chk("add_num0", 32'(num_input), 32'd0);
    chk("add_stB", 32'(state_dbg), 32'(ST_B));
    press(4'd3); press(4'd4);
    chk("b_d34", 32'(num_input), 32'd34);
    press(K_EQ);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_stCALC", 32'(state_dbg), 32'(ST_CALC));
    chk("calc_num_stable", 32'(num_input), 32'd34);
    chk("calc_op_stable", 32'(op_display), 32'd1);
    @(negedge clk);
    chk("add_busy_fall", 32'(busy), 32'd0);
    chk("add_result", 32'(result), 32'd46);
    chk("add_err", 32'(err), 32'd0);
    chk("add_stDONE", 32'(state_dbg), 32'(ST_DONE));

    // Equals ignored in S_DONE
    press(K_EQ);
    chk("done_eq_ignored", 32'(state_dbg), 32'(ST_DONE));

    // Chained: 46 + 4 = 50
    press(K_ADD);
    chk("chain_stB", 32'(state_dbg), 32'(ST_B));
    chk("chain_num0", 32'(num_input), 32'd0);
    press(4'd4); press(K_EQ);
    @(negedge clk);
    chk("chain_result", 32'(result), 32'd50);
    press(4'd7);
    chk("done_digit_num", 32'(num_input), 32'd7);
    chk("done_digit_op", 32'(op_display), 32'd0);
    chk("done_digit_result", 32'(result), 32'd50);
    chk("done_digit_stA", 32'(state_dbg), 32'(ST_A));

    // Digit overflow: 2,5,6 -> 25
    press(K_CLR);
    chk_idle("clr1");
    press(4'd2); chk("ovf_2", 32'(num_input), 32'd2);
    press(4'd5); chk("ovf_25", 32'(num_input), 32'd25);
    press(4'd6); chk("ovf_drop", 32'(num_input), 32'd25);
    press(K_RSV); chk("rsv_ignored", 32'(num_input), 32'd25);
    press(K_EQ); chk("a_eq_ignored", 32'(state_dbg), 32'(ST_A));

    // 99 * 99 = 9801, 8 busy cycles
    press(K_CLR);
    press(4'd9); press(4'd9); press(K_MUL);
    chk("mul_op", 32'(op_display), 32'd3);
    press(4'd9); press(4'd9); press(K_EQ);
    count_busy(n);
    chk("mul_busy_cycles", 32'(n), 32'd8);
    chk("mul_result", 32'(result), 32'd9801);
    chk("mul_err", 32'(err), 32'd0);
    chk("mul_stDONE", 32'(state_dbg), 32'(ST_DONE));
    // Result > 255: operator in S_DONE ignored
    press(K_ADD);
    chk("done_op_big_ignored", 32'(state_dbg), 32'(ST_DONE));
    // 255 * 255 = 65025 > 9999 -> error
    press(4'd2); press(4'd5); press(4'd5);
    chk("mul2_num", 32'(num_input), 32'd255);
    press(K_MUL); press(4'd2); press(4'd5); press(4'd5); press(K_EQ);
    count_busy(n);
    chk("mul2_busy_cycles", 32'(n), 32'd8);
    chk("mul2_err", 32'(err), 32'd1);
    chk("mul2_result", 32'(result), 32'd0);
    chk("mul2_stERR", 32'(state_dbg), 32'(ST_ERR));

    // 20 - 30 -> error, keys ignored, clear recovers
    press(K_CLR);
    press(4'd2); press(4'd0); press(K_SUB);
    chk("sub_op", 32'(op_display), 32'd2);
    press(4'd3); press(4'd0); press(K_EQ);
    count_busy(n);
    chk("sub_busy_cycles", 32'(n), 32'd1);
    chk("sub_err", 32'(err), 32'd1);
    chk("sub_result", 32'(result), 32'd0);
    press(4'd5);
    chk("err_digit_ignored", 32'(num_input), 32'd30);
    chk("err_stays", 32'(state_dbg), 32'(ST_ERR));
    press(K_CLR);
    chk_idle("err_clr");

    // 5 - 5 = 0 is not an error
    press(4'd5); press(K_SUB); press(4'd5); press(K_EQ);
    @(negedge clk);
    chk("sub_eq_result", 32'(result), 32'd0);
    chk("sub_eq_err", 32'(err), 32'd0);
    chk("sub_eq_stDONE", 32'(state_dbg), 32'(ST_DONE));

    // Operator replaced in S_B; key during busy ignored: 6 - 2 = 4
    press(K_CLR);
    press(4'd6); press(K_ADD); press(K_SUB);
    chk("op_replace", 32'(op_display), 32'd2);
    chk("op_replace_num", 32'(num_input), 32'd0);
    press(4'd2); press(K_EQ);
    press(4'd5);
    chk("busy_key_num", 32'(num_input), 32'd2);
    chk("busy_key_result", 32'(result), 32'd4);
    chk("busy_key_stDONE", 32'(state_dbg), 32'(ST_DONE));

    // Clear on the 4th busy cycle of a multiply
    press(K_CLR);
    press(4'd1); press(4'd2); press(K_MUL); press(4'd3); press(K_EQ);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("abort_busy4", 32'(busy), 32'd1);
    press(K_CLR);
    chk_idle("abort_clr");
    repeat (10) @(negedge clk);
    chk("abort_clr_result_later", 32'(result), 32'd0);

    // Same, aborted with rst_n
    press(4'd1); press(4'd2); press(K_MUL); press(4'd3); press(K_EQ);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rst_busy4", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_idle("rst_release");

    // Keys accepted right after reset release
    press(4'd8);
    chk("post_rst_digit", 32'(num_input), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
